// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code step arbiter: state encoding, counter width
// and the Gray successor function.
package gray_pkg;

  localparam int unsigned GRAY_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // 000>001>011>010>110>111>101>100>000
  function automatic logic [GRAY_W-1:0] gray_next(input logic [GRAY_W-1:0] cur);
    logic [GRAY_W-1:0] nxt;
    unique case (cur)
      3'b000:  nxt = 3'b001;
      3'b001:  nxt = 3'b011;
      3'b011:  nxt = 3'b010;
      3'b010:  nxt = 3'b110;
      3'b110:  nxt = 3'b111;
      3'b111:  nxt = 3'b101;
      3'b101:  nxt = 3'b100;
      3'b100:  nxt = 3'b000;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/gray_core.sv
// 3-bit Gray step counter; advances one code per enabled cycle and latches a
// sticky overflow on the 100->000 wrap.
module gray_core
  import gray_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  output logic [GRAY_W-1:0] Gray,
  output logic              Overflow
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Gray     <= '0;
      Overflow <= 1'b0;
    end else if (En) begin
      Gray <= gray_next(Gray);
      if (Gray == 3'b100) Overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/gray_step_arbiter.sv
// Round-robin arbiter granting a shared Gray step counter to one requester at a
// time for a latched number of steps, with a one-cycle Done pulse per transaction.
module gray_step_arbiter
  import gray_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned STEP_W = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        Req,
  input  logic [N_REQ*STEP_W-1:0] Steps,
  output logic [N_REQ-1:0]        Grant,
  output logic [N_REQ-1:0]        Done,
  output logic                    Busy,
  output logic [GRAY_W-1:0]       Gray,
  output logic                    Overflow
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  state_e            state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner;
  logic [STEP_W-1:0] remaining;

  logic [PTR_W-1:0]  pick;
  logic [N_REQ-1:0]  pick_oh;
  logic [STEP_W-1:0] pick_steps;
  logic              en;

  // First set Req bit searching from start upward, wrapping at N_REQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [PTR_W-1:0] start);
    logic [PTR_W-1:0] sel;
    logic             found;
    int unsigned      idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
    return sel;
  endfunction

  always_comb begin
    pick       = rr_pick(Req, ptr);
    pick_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
    pick_steps = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (PTR_W'(i) == pick) pick_steps = Steps[i*STEP_W +: STEP_W];
    end
  end

  assign en   = (state == RUN);
  assign Busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      remaining <= '0;
      Grant     <= '0;
      Done      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|Req) begin
            owner     <= pick;
            remaining <= pick_steps;
            Grant     <= pick_oh;
            if (pick_steps == '0) begin
              state <= DONE;
              Done  <= pick_oh;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          remaining <= remaining - STEP_W'(1);
          // This cycle issues the final step.
          if (remaining == STEP_W'(1)) begin
            state <= DONE;
            Done  <= Grant;
          end
        end
        DONE: begin
          Done  <= '0;
          Grant <= '0;
          ptr   <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  gray_core u_core (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (en),
    .Gray     (Gray),
    .Overflow (Overflow)
  );

endmodule
